uart_receive: RTL and testbench
===============================

// Module: uart_receive
// PURPOSE
//  Serial receive stage: the far-end consumer of the 8N1 stream produced by the UART transmitter.
//  Synchronises the async rx pin, validates the start bit at mid-bit, samples 8 data bits LSB first.
//  Checks the stop bit and presents each byte in a one-entry holding register.
//  Flags framing errors and overruns; the holding register is read by the UART register block.
// PARAMETERS
//  DIVISOR_WIDTH  16  width of clocks_per_bit; bit period = clocks_per_bit + 1 clk cycles (matches TX)
// PORTS
//  clk            in   1              clock
//  reset          in   1              asynchronous, active-high
//  clocks_per_bit in   DIVISOR_WIDTH  bit period minus one; static while a frame is in flight
//  uart_rx        in   1              async serial input, idle high
//  rx_read        in   1              consumer pop of holding register; clears rx_char_valid
//  rx_char        out  8              last good received byte
//  rx_char_valid  out  1              holding register full
//  frame_error    out  1              one-cycle pulse: stop bit sampled 0
//  overrun        out  1              one-cycle pulse: byte completed while holding register full
// BEHAVIOUR
//  Reset: state IDLE, sync flops 1, rx_char=0, rx_char_valid=0, frame_error=0, overrun=0,
//   counters=0. Reset mid-frame aborts it; nothing is delivered.
//  Sync: uart_rx passes through 2 flops (rx_sync); all decisions use rx_sync only.
//  Down counter bit_clocks [DIVISOR_WIDTH-1:0]; sample point = cycle where bit_clocks==0.
//  States:
//   IDLE:  rx_sync==0 -> START, bit_clocks=clocks_per_bit>>1 (half period, floor).
//   START: at 0: rx_sync==1 -> IDLE (glitch, no flags).
//          Else -> DATA, bit_clocks=clocks_per_bit, bit_count=0.
//   DATA:  at 0: shift={rx_sync, shift[7:1]}, bit_count++, reload; after 8th bit -> STOP.
//   STOP:  at 0: rx_sync==1 -> deliver, IDLE.
//          rx_sync==0 -> frame_error=1 for one cycle, byte discarded, -> BREAK.
//   BREAK: wait for rx_sync==1 -> IDLE (a held-low line yields exactly one error).
//  Deliver (registered, next edge): rx_char=shift, rx_char_valid=1.
//   If rx_char_valid was 1 and rx_read=0 that cycle, overrun=1 for one cycle; new byte replaces old.
//  rx_read with rx_char_valid=0 is ignored. rx_read on the delivery cycle: valid stays 1, no overrun.
//  Latency: pin fall to rx_char_valid = 2 (sync) + 1 + (cpb>>1)+1 + 9*(cpb+1) + 1 cycles, approximately.
//  Sampling mid-bit tolerates about +/-4% rate mismatch; clocks_per_bit >= 3 required.
// STRUCTURE
//  uart_pkg: typedef enum logic[2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} uart_rx_state_t;
//   START_BIT/STOP_BIT constants shared with the transmitter.
//  Sub-module: synchronizer #(.WIDTH(1), .RESET_STATE(1)) for uart_rx; the rest is one always_ff.
// TESTING (clocks_per_bit=7 -> 8 clk/bit, TX instance looped back unless stated)
//  TX 0x55 -> rx_char=0x55, rx_char_valid=1, no flags. rx_read -> valid=0 next cycle.
//  Sweep 0x00, 0xFF, 0xA3, 0x80 back-to-back -> each delivered in order, read between.
//  Drive rx low 3 clk, then high -> stays IDLE; no valid, no frame_error.
//  Hand-drive 0xA3 with stop=0, hold low 40 clk -> one frame_error pulse, valid=0.
//   Then TX 0x3C -> received OK.
//  TX 0x11, 0x22 with no read -> overrun pulse once, rx_char=0x22.
//   Repeat with rx_read on the delivery cycle -> no overrun.
//  Assert reset during DATA bit 4 -> all outputs 0; next TX 0x96 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding and line-level bit values.
// Both the transmitter and the receiver import these.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for asynchronous inputs.
// The reset value is chosen so that an idle line does not look like activity.
module synchronizer #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_STATE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_bits,
  output logic [WIDTH-1:0] sync_bits
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta      <= RESET_STATE;
      sync_bits <= RESET_STATE;
    end else begin
      meta      <= async_bits;
      sync_bits <= meta;
    end
  end

endmodule

// File: rtl/uart_receive.sv
// 8N1 serial receiver: mid-bit sampling, one-entry holding register,
// framing-error and overrun pulses.
//
//  state    | meaning
//  RX_IDLE  | line idle, waiting for a falling edge
//  RX_START | half-bit wait, then confirm that the start bit is still low
//  RX_DATA  | sample 8 data bits, LSB first, one per bit period
//  RX_STOP  | sample the stop bit; deliver the byte or flag a framing error
//  RX_BREAK | line held low after a framing error; wait for it to return high
module uart_receive
  import uart_pkg::*;
#(
  parameter int DIVISOR_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DIVISOR_WIDTH-1:0] clocks_per_bit,
  input  logic                     uart_rx,
  input  logic                     rx_read,
  output logic [7:0]               rx_char,
  output logic                     rx_char_valid,
  output logic                     frame_error,
  output logic                     overrun
);

  logic rx_sync;

  synchronizer #(
    .WIDTH       (1),
    .RESET_STATE (1'b1)
  ) u_rx_sync (
    .clk        (clk),
    .reset      (reset),
    .async_bits (uart_rx),
    .sync_bits  (rx_sync)
  );

  uart_rx_state_t           state, state_next;
  logic [DIVISOR_WIDTH-1:0] bit_clocks, bit_clocks_next;
  logic [2:0]               bit_count, bit_count_next;
  logic [7:0]               shift, shift_next;
  logic [7:0]               rx_char_next;
  logic                     rx_char_valid_next;
  logic                     frame_error_next;
  logic                     overrun_next;
  logic                     at_sample;
  logic                     deliver;

  assign at_sample = (bit_clocks == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RX_IDLE;
      bit_clocks    <= '0;
      bit_count     <= '0;
      shift         <= '0;
      rx_char       <= '0;
      rx_char_valid <= 1'b0;
      frame_error   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_next;
      bit_clocks    <= bit_clocks_next;
      bit_count     <= bit_count_next;
      shift         <= shift_next;
      rx_char       <= rx_char_next;
      rx_char_valid <= rx_char_valid_next;
      frame_error   <= frame_error_next;
      overrun       <= overrun_next;
    end
  end

  always_comb begin
    state_next         = state;
    bit_clocks_next    = at_sample ? bit_clocks : bit_clocks - 1'b1;
    bit_count_next     = bit_count;
    shift_next         = shift;
    frame_error_next   = 1'b0;
    deliver            = 1'b0;

    case (state)
      RX_IDLE: begin
        bit_clocks_next = '0;
        if (rx_sync == START_BIT) begin
          state_next      = RX_START;
          bit_clocks_next = clocks_per_bit >> 1;
        end
      end
      RX_START: begin
        if (at_sample) begin
          if (rx_sync == STOP_BIT) begin
            state_next = RX_IDLE;
          end else begin
            state_next      = RX_DATA;
            bit_clocks_next = clocks_per_bit;
            bit_count_next  = '0;
          end
        end
      end
      RX_DATA: begin
        if (at_sample) begin
          shift_next      = {rx_sync, shift[7:1]};
          bit_count_next  = bit_count + 3'd1;
          bit_clocks_next = clocks_per_bit;
          if (bit_count == 3'(DATA_BITS - 1)) begin
            state_next = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (at_sample) begin
          if (rx_sync == STOP_BIT) begin
            deliver    = 1'b1;
            state_next = RX_IDLE;
          end else begin
            frame_error_next = 1'b1;
            state_next       = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        bit_clocks_next = '0;
        if (rx_sync == STOP_BIT) begin
          state_next = RX_IDLE;
        end
      end
      default: begin
        state_next      = RX_IDLE;
        bit_clocks_next = '0;
      end
    endcase
  end

  // A read on the delivery cycle pops the old byte, so the new one lands cleanly.
  always_comb begin
    rx_char_next       = rx_char;
    rx_char_valid_next = rx_char_valid && !rx_read;
    overrun_next       = 1'b0;
    if (deliver) begin
      rx_char_next       = shift;
      rx_char_valid_next = 1'b1;
      overrun_next       = rx_char_valid && !rx_read;
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Self-checking bench for uart_receive: a behavioural 8N1 driver on uart_rx,
// expected bytes kept in a queue, flag pulses counted by a monitor.
module tb_uart_receive;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] clocks_per_bit = 16'd7;
  logic        uart_rx = 1'b1;
  logic        rx_read = 1'b0;
  logic [7:0]  rx_char;
  logic        rx_char_valid;
  logic        frame_error;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  int  cyc = 0;
  int  fe_cnt = 0;
  int  ov_cnt = 0;
  int  rise_cyc = 0;
  logic valid_d = 1'b0;
  int  last_t0 = 0;
  bit  abort = 0;

  logic [7:0] exp_q[$];

  uart_receive #(.DIVISOR_WIDTH(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .clocks_per_bit (clocks_per_bit),
    .uart_rx        (uart_rx),
    .rx_read        (rx_read),
    .rx_char        (rx_char),
    .rx_char_valid  (rx_char_valid),
    .frame_error    (frame_error),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
    if (rx_char_valid === 1'b1 && valid_d !== 1'b1) rise_cyc <= cyc;
    valid_d <= rx_char_valid;
  end

  // Drives one frame; optionally pulses rx_read on the cycle whose closing
  // edge samples the stop bit (start seen 3 edges in, half-bit, 9 full bits).
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input bit rd_at_deliver);
    int per;
    int dly;
    int t0;
    logic [9:0] bits;
    bits = {stop_val, b, 1'b0};
    per  = int'(clocks_per_bit) + 1;
    dly  = 4 + (int'(clocks_per_bit) >> 1) + 9 * per;
    @(posedge clk); #1;
    t0 = cyc;
    last_t0 = t0;
    for (int k = 0; k < 10 * per; k++) begin
      if (abort) begin
        uart_rx = 1'b1;
        break;
      end
      uart_rx = bits[k / per];
      if (rd_at_deliver) rx_read = (cyc == t0 + dly - 1);
      @(posedge clk); #1;
    end
    if (rd_at_deliver) rx_read = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (rx_char_valid === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic pop_read();
    @(negedge clk);
    rx_read = 1'b1;
    @(posedge clk); #1;
    rx_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_char !== 8'h00) begin errors++; $display("FAIL reset_rx_char got=%h exp=00", rx_char); end
    checks++; if (rx_char_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_char_valid); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error got=%b exp=0", frame_error); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    int fe0, ov0, lat, lat_exp;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h55, 1'b1, 0);
    wait_valid(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout valid got=0 exp=1"); end
    checks++; if (rx_char !== 8'h55) begin errors++; $display("FAIL basic_char got=%h exp=55", rx_char); end
    repeat (2) @(negedge clk);
    lat_exp = 2 + 1 + ((int'(clocks_per_bit) >> 1) + 1) + 9 * (int'(clocks_per_bit) + 1) + 1;
    lat = rise_cyc - last_t0;
    checks++; if (lat < lat_exp - 2 || lat > lat_exp + 2) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d+-2", lat, lat_exp); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL basic_frame_error pulses got=%0d exp=0", fe_cnt - fe0); end
    checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL basic_overrun pulses got=%0d exp=0", ov_cnt - ov0); end
    pop_read();
    checks++; if (rx_char_valid !== 1'b0) begin errors++; $display("FAIL basic_read valid got=%b exp=0", rx_char_valid); end
  endtask

  task automatic test_sweep();
    logic [7:0] pat [4] = '{8'h00, 8'hFF, 8'hA3, 8'h80};
    bit ok;
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 4; i++) begin
      send_frame(pat[i], 1'b1, 0);
      wait_valid(40, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sweep_timeout idx=%0d valid got=0 exp=1", i); end
      checks++; if (rx_char !== pat[i]) begin errors++; $display("FAIL sweep_char idx=%0d got=%h exp=%h", i, rx_char, pat[i]); end
      pop_read();
      checks++; if (rx_char_valid !== 1'b0) begin errors++; $display("FAIL sweep_read idx=%0d valid got=%b exp=0", i, rx_char_valid); end
    end
    repeat (2) @(negedge clk);
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL sweep_frame_error pulses got=%0d exp=0", fe_cnt - fe0); end
    checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL sweep_overrun pulses got=%0d exp=0", ov_cnt - ov0); end
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    @(posedge clk); #1;
    uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (rx_char_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got=%b exp=0", rx_char_valid); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL glitch_frame_error pulses got=%0d exp=0", fe_cnt - fe0); end
  endtask

  task automatic test_frame_error();
    bit ok;
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0, 0);
    repeat (40) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (rx_char_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got=%b exp=0", rx_char_valid); end
    send_frame(8'h3C, 1'b1, 0);
    wait_valid(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ferr_recover_timeout valid got=0 exp=1"); end
    checks++; if (rx_char !== 8'h3C) begin errors++; $display("FAIL ferr_recover_char got=%h exp=3c", rx_char); end
    pop_read();
  endtask

  task automatic test_overrun();
    bit ok;
    int ov0;
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    wait_valid(40, ok);
    repeat (3) @(negedge clk);
    checks++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL overrun_pulses got=%0d exp=1", ov_cnt - ov0); end
    checks++; if (rx_char !== 8'h22) begin errors++; $display("FAIL overrun_char got=%h exp=22", rx_char); end
    checks++; if (rx_char_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid got=%b exp=1", rx_char_valid); end
    pop_read();
    checks++; if (rx_char_valid !== 1'b0) begin errors++; $display("FAIL overrun_read valid got=%b exp=0", rx_char_valid); end

    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 0);
    wait_valid(40, ok);
    checks++; if (!ok || rx_char !== 8'h11) begin errors++; $display("FAIL overrun2_first got=%h valid=%b exp=11", rx_char, ok); end
    send_frame(8'h22, 1'b1, 1);
    repeat (3) @(negedge clk);
    checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL read_on_deliver_overrun pulses got=%0d exp=0", ov_cnt - ov0); end
    checks++; if (rx_char !== 8'h22) begin errors++; $display("FAIL read_on_deliver_char got=%h exp=22", rx_char); end
    checks++; if (rx_char_valid !== 1'b1) begin errors++; $display("FAIL read_on_deliver_valid got=%b exp=1", rx_char_valid); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    fork
      send_frame(8'h5A, 1'b1, 0);
      begin
        repeat (46) @(posedge clk);
        #1;
        reset = 1'b1;
        abort = 1;
        #1;
        checks++; if (rx_char !== 8'h00) begin errors++; $display("FAIL midreset_char got=%h exp=00", rx_char); end
        checks++; if (rx_char_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b exp=0", rx_char_valid); end
        checks++; if (frame_error !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL midreset_flags got=%b%b exp=00", frame_error, overrun); end
        repeat (12) @(posedge clk);
        #1;
        reset = 1'b0;
        abort = 0;
      end
    join
    repeat (120) @(negedge clk);
    checks++; if (rx_char_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_delivery valid got=%b exp=0", rx_char_valid); end
    send_frame(8'h96, 1'b1, 0);
    wait_valid(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midreset_next_timeout valid got=0 exp=1"); end
    checks++; if (rx_char !== 8'h96) begin errors++; $display("FAIL midreset_next_char got=%h exp=96", rx_char); end
    pop_read();
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] b, e;
    int fe0, ov0;
    for (int round = 0; round < 3; round++) begin
      clocks_per_bit = (round == 0) ? 16'd7 : 16'($urandom_range(3, 20));
      fe0 = fe_cnt; ov0 = ov_cnt;
      for (int i = 0; i < 6; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        send_frame(b, 1'b1, 0);
        wait_valid(12 * (int'(clocks_per_bit) + 1) + 10, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL random_timeout cpb=%0d idx=%0d valid got=0 exp=1", clocks_per_bit, i); end
        else if (rx_char !== e) begin errors++; $display("FAIL random_char cpb=%0d idx=%0d got=%h exp=%h", clocks_per_bit, i, rx_char, e); end
        pop_read();
        repeat ($urandom_range(0, 5)) @(posedge clk);
      end
      repeat (2) @(negedge clk);
      checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin errors++; $display("FAIL random_flags cpb=%0d fe=%0d ov=%0d exp=0,0", clocks_per_bit, fe_cnt - fe0, ov_cnt - ov0); end
    end
    clocks_per_bit = 16'd7;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
